alu_1_pipe: RTL and testbench

- Next-generation single-container ALU for the RMT action stage.
- Computes one result per cycle. The latency is parametrised and the pipeline honours valid/ready backpressure.
- Extends the opcode set with logic, min/max and saturating arithmetic, and reports an overflow flag.
- Sits between sub_action operand extraction and PHV re-assembly. One instance is used per container.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_op_comb.sv | 51 +++++
 rtl/alu_1_pipe.sv | 106 ++++++++++
 tb/tb_alu_1_pipe.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings shared by the action-stage ALU.
package alu_pkg;

  localparam int OPCODE_W = 8;

  typedef logic [OPCODE_W-1:0] opcode_t;

  localparam opcode_t OP_ADD  = 8'h01;
  localparam opcode_t OP_SUB  = 8'h02;
  localparam opcode_t OP_AND  = 8'h03;
  localparam opcode_t OP_OR   = 8'h04;
  localparam opcode_t OP_XOR  = 8'h05;
  localparam opcode_t OP_MAX  = 8'h06;
  localparam opcode_t OP_MIN  = 8'h07;
  localparam opcode_t OP_ADDI = 8'h09;
  localparam opcode_t OP_SUBI = 8'h0A;
  localparam opcode_t OP_SADD = 8'h0B;
  localparam opcode_t OP_SSUB = 8'h0C;
  localparam opcode_t OP_SET  = 8'h0E;

endpackage

// File: rtl/alu_op_comb.sv
// rtl/alu_op_comb.sv - combinational opcode decode and datapath with carry/borrow flag.
module alu_op_comb
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 48
) (
  input  logic [OPCODE_W-1:0]   opcode_i,
  input  logic [DATA_WIDTH-1:0] op1_i,
  input  logic [DATA_WIDTH-1:0] op2_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  ovf_o
);

  // One extra bit so the top bit is the carry (add) or borrow (sub).
  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] diff;

  assign sum  = {1'b0, op1_i} + {1'b0, op2_i};
  assign diff = {1'b0, op1_i} - {1'b0, op2_i};

  always_comb begin
    result_o = op1_i;
    ovf_o    = 1'b0;
    case (opcode_i)
      OP_ADD, OP_ADDI: begin
        result_o = sum[DATA_WIDTH-1:0];
        ovf_o    = sum[DATA_WIDTH];
      end
      OP_SUB, OP_SUBI: begin
        result_o = diff[DATA_WIDTH-1:0];
        ovf_o    = diff[DATA_WIDTH];
      end
      OP_AND: result_o = op1_i & op2_i;
      OP_OR:  result_o = op1_i | op2_i;
      OP_XOR: result_o = op1_i ^ op2_i;
      OP_MAX: result_o = (op1_i >= op2_i) ? op1_i : op2_i;
      OP_MIN: result_o = (op1_i <= op2_i) ? op1_i : op2_i;
      OP_SADD: begin
        result_o = sum[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : sum[DATA_WIDTH-1:0];
        ovf_o    = sum[DATA_WIDTH];
      end
      OP_SSUB: begin
        result_o = diff[DATA_WIDTH] ? {DATA_WIDTH{1'b0}} : diff[DATA_WIDTH-1:0];
        ovf_o    = diff[DATA_WIDTH];
      end
      OP_SET:  result_o = op2_i;
      default: result_o = op1_i;
    endcase
  end

endmodule

// File: rtl/alu_1_pipe.sv
// rtl/alu_1_pipe.sv - single-container ALU with a LATENCY-deep valid/ready pipeline.
module alu_1_pipe
  import alu_pkg::*;
#(
  parameter int STAGE_ID   = 0,
  parameter int ACTION_LEN = 64,
  parameter int DATA_WIDTH = 48,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ACTION_LEN-1:0] action_in,
  input  logic                  action_valid,
  output logic                  action_ready,
  input  logic [DATA_WIDTH-1:0] operand_1_in,
  input  logic [DATA_WIDTH-1:0] operand_2_in,
  output logic [DATA_WIDTH-1:0] container_out,
  output logic                  container_out_ovf,
  output logic                  container_out_valid,
  input  logic                  container_out_ready
);

  localparam int unused_stage_id = STAGE_ID;

  logic [OPCODE_W-1:0] opcode;
  assign opcode = action_in[ACTION_LEN-1 -: OPCODE_W];

  generate
    if (ACTION_LEN > OPCODE_W) begin : g_unused_action
      logic unused_action_bits;
      assign unused_action_bits = ^action_in[ACTION_LEN-OPCODE_W-1:0];
    end
  endgenerate

  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_ovf;

  alu_op_comb #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_op (
    .opcode_i(opcode),
    .op1_i   (operand_1_in),
    .op2_i   (operand_2_in),
    .result_o(alu_result),
    .ovf_o   (alu_ovf)
  );

  logic [LATENCY-1:0]                 valid_q, valid_d;
  logic [LATENCY-1:0]                 ovf_q, ovf_d;
  logic [LATENCY-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [LATENCY-1:0]                 load;
  logic                               accept;

  // A stage may load when it or any stage after it is empty, or the output drains;
  // this folds the per-stage advance chain into a running OR from the output back.
  always_comb begin : load_chain
    logic room;
    room = container_out_ready;
    for (int i = LATENCY - 1; i >= 0; i--) begin
      room    = room | ~valid_q[i];
      load[i] = room;
    end
  end

  assign action_ready = load[0];
  assign accept       = action_valid & load[0];

  always_comb begin
    valid_d = valid_q;
    ovf_d   = ovf_q;
    data_d  = data_q;
    if (load[0]) begin
      valid_d[0] = action_valid;
      if (accept) begin
        data_d[0] = alu_result;
        ovf_d[0]  = alu_ovf;
      end
    end
    for (int i = 1; i < LATENCY; i++) begin
      if (load[i]) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) begin
          data_d[i] = data_q[i-1];
          ovf_d[i]  = ovf_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ovf_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
    end
  end

  assign container_out       = data_q[LATENCY-1];
  assign container_out_ovf   = ovf_q[LATENCY-1];
  assign container_out_valid = valid_q[LATENCY-1];

endmodule

// File: tb/tb_alu_1_pipe.sv
// tb/tb_alu_1_pipe.sv - scoreboard bench for alu_1_pipe with an arithmetic reference model.
module tb_alu_1_pipe;
  import alu_pkg::*;

  localparam int AL  = 64;
  localparam int DW  = 48;
  localparam int LAT = 2;
  localparam longint unsigned MAXV = 64'h0000_FFFF_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AL-1:0] action_in = '0;
  logic          action_valid = 1'b0;
  logic          action_ready;
  logic [DW-1:0] operand_1_in = '0;
  logic [DW-1:0] operand_2_in = '0;
  logic [DW-1:0] container_out;
  logic          container_out_ovf;
  logic          container_out_valid;
  logic          container_out_ready = 1'b1;

  alu_1_pipe #(
    .STAGE_ID  (0),
    .ACTION_LEN(AL),
    .DATA_WIDTH(DW),
    .LATENCY   (LAT)
  ) u_dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .action_in          (action_in),
    .action_valid       (action_valid),
    .action_ready       (action_ready),
    .operand_1_in       (operand_1_in),
    .operand_2_in       (operand_2_in),
    .container_out      (container_out),
    .container_out_ovf  (container_out_ovf),
    .container_out_valid(container_out_valid),
    .container_out_ready(container_out_ready)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  longint unsigned exp_d_q[$];
  bit              exp_o_q[$];
  int unsigned     exp_c_q[$];
  bit              lat_en = 1'b0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Unsigned arithmetic on plain 64-bit integers, clamped and flagged from the opcode rules.
  function automatic void ref_model(input logic [7:0] op, input longint unsigned a,
                                    input longint unsigned b, output longint unsigned r,
                                    output bit o);
    longint unsigned s;
    s = a + b;
    r = a;
    o = 1'b0;
    case (op)
      8'h01, 8'h09: begin o = (s > MAXV); r = s & MAXV; end
      8'h02, 8'h0A: begin o = (b > a); r = (a - b) & MAXV; end
      8'h03: r = a & b;
      8'h04: r = a | b;
      8'h05: r = a ^ b;
      8'h06: r = (a > b) ? a : b;
      8'h07: r = (a < b) ? a : b;
      8'h0B: begin o = (s > MAXV); r = o ? MAXV : s; end
      8'h0C: begin o = (b > a); r = o ? 64'd0 : (a - b); end
      8'h0E: r = b;
      default: r = a;
    endcase
  endfunction

  task automatic send(input logic [7:0] opc, input longint unsigned a, input longint unsigned b,
                      input int rdy, input int budget, output bit acc);
    logic [AL-1:0]   aw;
    longint unsigned r;
    bit              o;
    acc = 1'b0;
    aw = {$urandom, $urandom};
    aw[AL-1 -: 8] = opc;
    @(negedge clk);
    action_in    = aw;
    operand_1_in = a[DW-1:0];
    operand_2_in = b[DW-1:0];
    action_valid = 1'b1;
    if (rdy >= 0) container_out_ready = rdy[0];
    for (int n = 0; n < budget; n++) begin
      if (n > 0) @(negedge clk);
      #1;
      if (action_ready) begin
        ref_model(opc, a, b, r, o);
        exp_d_q.push_back(r);
        exp_o_q.push_back(o);
        exp_c_q.push_back(cyc);
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk);
  endtask

  task automatic send_ok(input logic [7:0] opc, input longint unsigned a,
                         input longint unsigned b, input int rdy);
    bit acc;
    send(opc, a, b, rdy, 20, acc);
    chk("accept", acc, 1);
  endtask

  task automatic idle(input int rdy);
    @(negedge clk);
    action_valid = 1'b0;
    if (rdy >= 0) container_out_ready = rdy[0];
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && exp_d_q.size() != 0; n++) @(negedge clk);
    #2;
    chk("drain outstanding", exp_d_q.size(), 0);
  endtask

  function automatic longint unsigned rnd48();
    case ($urandom_range(0, 3))
      0: return 64'd0;
      1: return MAXV;
      2: return longint'($urandom_range(0, 15));
      default: return {$urandom, $urandom} & MAXV;
    endcase
  endfunction

  function automatic logic [7:0] rnd_op();
    if ($urandom_range(0, 4) == 0) return 8'($urandom_range(0, 255));
    case ($urandom_range(0, 11))
      0: return OP_ADD;   1: return OP_ADDI;  2: return OP_SUB;  3: return OP_SUBI;
      4: return OP_AND;   5: return OP_OR;    6: return OP_XOR;  7: return OP_MAX;
      8: return OP_MIN;   9: return OP_SADD;  10: return OP_SSUB;
      default: return OP_SET;
    endcase
  endfunction

  // Output monitor: pops the scoreboard on every output transfer and checks stall stability.
  initial begin
    bit              prev_stall;
    longint unsigned pd;
    bit              po;
    longint unsigned e;
    bit              eo;
    int unsigned     c;
    prev_stall = 1'b0;
    pd = 0;
    po = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        chk("stall valid", container_out_valid, 1);
        chk("stall data", container_out, pd);
        chk("stall ovf", container_out_ovf, po);
      end
      prev_stall = container_out_valid && !container_out_ready;
      pd = container_out;
      po = container_out_ovf;
      if (container_out_valid && container_out_ready) begin
        if (exp_d_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected output: got 0x%0h with no item outstanding", container_out);
        end else begin
          e  = exp_d_q.pop_front();
          eo = exp_o_q.pop_front();
          c  = exp_c_q.pop_front();
          chk("result", container_out, e);
          chk("ovf", container_out_ovf, eo);
          if (lat_en) chk("latency", cyc - c, LAT);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    bit done;
    done = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset valid", container_out_valid, 0);
    chk("reset data", container_out, 0);
    chk("reset ovf", container_out_ovf, 0);
    chk("reset action_ready", action_ready, 1);

    // Back-to-back directed ops with the output always ready.
    lat_en = 1'b1;
    send_ok(OP_ADD, 5, 7, 1);
    send_ok(OP_SUB, 3, 5, 1);
    send_ok(OP_SADD, 64'hFFFF_FFFF_FFF0, 64'h20, 1);
    send_ok(OP_SSUB, 3, 9, 1);
    send_ok(OP_AND, 16'hF0F0, 16'h0FF0, 1);
    send_ok(OP_OR, 16'hF0F0, 16'h0FF0, 1);
    send_ok(OP_XOR, 16'hF0F0, 16'h0FF0, 1);
    send_ok(OP_MAX, 16'hF0F0, 16'h0FF0, 1);
    send_ok(OP_MIN, 16'hF0F0, 16'h0FF0, 1);
    send_ok(OP_SET, 16'h5555, 16'h1234, 1);
    send_ok(8'h55, 16'hABCD, 16'h1111, 1);
    send_ok(OP_ADDI, MAXV, 1, 1);
    idle(1);
    drain(30);
    lat_en = 1'b0;

    // Full stall: exactly LAT accepted, extra offers refused, then valid drops.
    for (int k = 0; k < LAT + 2; k++) begin
      send(OP_ADD, 100 + k, k, 0, 1, acc);
      chk("stall accept count", acc, (k < LAT) ? 1 : 0);
    end
    idle(0);
    #1;
    chk("full pipe action_ready", action_ready, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("full pipe valid", container_out_valid, 1);
    send(OP_XOR, 7, 3, 1, 1, acc);
    chk("accept with output transfer", acc, 1);
    @(negedge clk);
    action_valid = 1'b0;
    container_out_ready = 1'b0;
    #1;
    chk("occupancy unchanged", action_ready, 0);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      container_out_ready = 1'b1;
      #1;
      chk("drain back-to-back", container_out_valid, 1);
    end
    drain(20);

    // Bubble collapse under a long stall.
    send_ok(OP_OR, 16'h11, 16'h22, 0);
    repeat (10) idle(0);
    send(OP_MIN, 9, 4, 0, 1, acc);
    chk("bubble second accept", acc, 1);
    idle(1);
    #1;
    chk("bubble first out", container_out_valid, 1);
    @(negedge clk);
    #1;
    chk("bubble second out", container_out_valid, 1);
    drain(20);

    // Asynchronous reset with items in flight.
    send_ok(OP_ADD, 1, 2, 0);
    send_ok(OP_SUB, 9, 2, 0);
    @(negedge clk);
    action_valid = 1'b0;
    container_out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid reset valid", container_out_valid, 0);
    chk("mid reset data", container_out, 0);
    chk("mid reset ovf", container_out_ovf, 0);
    exp_d_q.delete();
    exp_o_q.delete();
    exp_c_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post reset action_ready", action_ready, 1);
    repeat (5) @(negedge clk);
    #1;
    chk("post reset no stale", container_out_valid, 0);

    // Random traffic against random backpressure.
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          send(rnd_op(), rnd48(), rnd48(), -1, 60, acc);
          chk("random accept", acc, 1);
          if ($urandom_range(0, 3) == 0) idle(-1);
        end
        idle(-1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          container_out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(negedge clk);
    container_out_ready = 1'b1;
    drain(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
